// File: rtl/cgra_pkg.sv
// ---------------------------------------------------------------------------
// cgra_pkg
// Shared definitions for the single-tile CGRA:
//   - datapath width W
//   - configuration register addresses
//   - SRC_A / SRC_B field positions
//   - ALU opcode enum
//   - packed configuration record
//   - operand-select helper
// ---------------------------------------------------------------------------
package cgra_pkg;

  localparam int W      = 16;
  localparam int CFG_AW = 32;
  localparam int CFG_DW = 32;

  // Register addresses. Only addr[15:0] is decoded; 0 means "no write".
  localparam logic [15:0] ADDR_SRC_A   = 16'h0001;
  localparam logic [15:0] ADDR_SRC_B   = 16'h0002;
  localparam logic [15:0] ADDR_CONST   = 16'h0003;
  localparam logic [15:0] ADDR_OP      = 16'h0004;
  localparam logic [15:0] ADDR_OUT_CFG = 16'h0005;

  // Operand-source field layout, shared by SRC_A and SRC_B.
  localparam int SRC_SIDE_LSB  = 0;
  localparam int SRC_SIDE_MSB  = 1;
  localparam int SRC_CONST_BIT = 2;

  // Output-config bit positions.
  localparam int OUT_EN_BIT  = 0;
  localparam int OUT_REG_BIT = 1;

  // Opcodes 13..15 are deliberately absent: they produce a zero result.
  typedef enum logic [3:0] {
    OP_PASS = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_MUL  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_SHL  = 4'd7,
    OP_SHR  = 4'd8,
    OP_MIN  = 4'd9,
    OP_MAX  = 4'd10,
    OP_EQ   = 4'd11,
    OP_ACC  = 4'd12
  } op_e;

  typedef struct packed {
    logic [2:0]   src_a;
    logic [2:0]   src_b;
    logic [W-1:0] cval;
    logic [3:0]   op;
    logic [1:0]   out_cfg;
  } cfg_t;

  // Pick an operand: either the constant register or one of the side buses.
  function automatic logic [W-1:0] sel_operand(
    input logic [2:0]          sel,
    input logic [3:0][W-1:0]   sides,
    input logic [W-1:0]        cval
  );
    if (sel[SRC_CONST_BIT]) begin
      return cval;
    end
    return sides[sel[SRC_SIDE_MSB:SRC_SIDE_LSB]];
  endfunction

endpackage

// File: rtl/cgra_pe.sv
// ---------------------------------------------------------------------------
// cgra_pe
// Processing element: two operand muxes, a 16-bit ALU, the accumulator
// (ACC) and the optional output register (OREG).
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   i_cfg     in   current configuration record
//   i_op_wr   in   high in the cycle an OP register write is presented
//   i_sides   in   side buses S0..S3 (index 0 = S0)
//   o_out     out  tile result routed to the S0 output pads
// ---------------------------------------------------------------------------
module cgra_pe
  import cgra_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  cfg_t                i_cfg,
  input  logic                i_op_wr,
  input  logic [3:0][W-1:0]   i_sides,
  output logic [W-1:0]        o_out
);

  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic [W-1:0] w_result;
  logic [W-1:0] r_acc;
  logic [W-1:0] r_oreg;

  assign w_a = sel_operand(i_cfg.src_a, i_sides, i_cfg.cval);
  assign w_b = sel_operand(i_cfg.src_b, i_sides, i_cfg.cval);

  // All arithmetic is evaluated in a 16-bit context, so overflow wraps.
  always_comb begin
    w_result = '0;
    case (i_cfg.op)
      OP_PASS: w_result = w_a;
      OP_ADD:  w_result = w_a + w_b;
      OP_SUB:  w_result = w_a - w_b;
      OP_MUL:  w_result = w_a * w_b;
      OP_AND:  w_result = w_a & w_b;
      OP_OR:   w_result = w_a | w_b;
      OP_XOR:  w_result = w_a ^ w_b;
      OP_SHL:  w_result = w_a << w_b[3:0];
      OP_SHR:  w_result = w_a >> w_b[3:0];
      OP_MIN:  w_result = (w_a < w_b) ? w_a : w_b;
      OP_MAX:  w_result = (w_a > w_b) ? w_a : w_b;
      OP_EQ:   w_result = {{(W-1){1'b0}}, (w_a == w_b)};
      OP_ACC:  w_result = r_acc;            // pre-update value
      default: w_result = '0;
    endcase
  end

  // An OP write clears ACC and takes priority over accumulation, so
  // rewriting OP=12 restarts the sum from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_op_wr) begin
      r_acc <= '0;
    end else if (i_cfg.op == OP_ACC) begin
      r_acc <= r_acc + w_a;
    end
  end

  // OREG tracks the result every cycle; it is only visible when selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oreg <= '0;
    end else begin
      r_oreg <= w_result;
    end
  end

  always_comb begin
    o_out = '0;
    if (i_cfg.out_cfg[OUT_EN_BIT]) begin
      o_out = i_cfg.out_cfg[OUT_REG_BIT] ? r_oreg : w_result;
    end
  end

endmodule

// File: rtl/cgra_top.sv
// ---------------------------------------------------------------------------
// cgra_top
// Chip-level top of a one-tile CGRA. Holds the write-only configuration
// register file, packs the side pads into 16-bit buses (T0 = MSB), unpacks
// the tile result onto the S0 output pads and stubs out JTAG.
// Ports:
//   clk_in                  in   sole clock
//   reset_in                in   asynchronous active-low reset
//   config_addr_in[31:0]    in   config address, [15:0] decoded, 0 = no-op
//   config_data_in[31:0]    in   config write data
//   pad_S{0..3}_T{0..15}_in in   side input pads
//   pad_S0_T{0..15}_out     out  S0 output pads
//   tdi, tms, tck, trst_n   in   JTAG, unused
//   tdo                     out  JTAG, tied low
// ---------------------------------------------------------------------------
module cgra_top
  import cgra_pkg::*;
(
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [CFG_AW-1:0] config_addr_in,
  input  logic [CFG_DW-1:0] config_data_in,
  input  logic pad_S0_T0_in,  pad_S0_T1_in,  pad_S0_T2_in,  pad_S0_T3_in,
               pad_S0_T4_in,  pad_S0_T5_in,  pad_S0_T6_in,  pad_S0_T7_in,
               pad_S0_T8_in,  pad_S0_T9_in,  pad_S0_T10_in, pad_S0_T11_in,
               pad_S0_T12_in, pad_S0_T13_in, pad_S0_T14_in, pad_S0_T15_in,
  input  logic pad_S1_T0_in,  pad_S1_T1_in,  pad_S1_T2_in,  pad_S1_T3_in,
               pad_S1_T4_in,  pad_S1_T5_in,  pad_S1_T6_in,  pad_S1_T7_in,
               pad_S1_T8_in,  pad_S1_T9_in,  pad_S1_T10_in, pad_S1_T11_in,
               pad_S1_T12_in, pad_S1_T13_in, pad_S1_T14_in, pad_S1_T15_in,
  input  logic pad_S2_T0_in,  pad_S2_T1_in,  pad_S2_T2_in,  pad_S2_T3_in,
               pad_S2_T4_in,  pad_S2_T5_in,  pad_S2_T6_in,  pad_S2_T7_in,
               pad_S2_T8_in,  pad_S2_T9_in,  pad_S2_T10_in, pad_S2_T11_in,
               pad_S2_T12_in, pad_S2_T13_in, pad_S2_T14_in, pad_S2_T15_in,
  input  logic pad_S3_T0_in,  pad_S3_T1_in,  pad_S3_T2_in,  pad_S3_T3_in,
               pad_S3_T4_in,  pad_S3_T5_in,  pad_S3_T6_in,  pad_S3_T7_in,
               pad_S3_T8_in,  pad_S3_T9_in,  pad_S3_T10_in, pad_S3_T11_in,
               pad_S3_T12_in, pad_S3_T13_in, pad_S3_T14_in, pad_S3_T15_in,
  output logic pad_S0_T0_out,  pad_S0_T1_out,  pad_S0_T2_out,  pad_S0_T3_out,
               pad_S0_T4_out,  pad_S0_T5_out,  pad_S0_T6_out,  pad_S0_T7_out,
               pad_S0_T8_out,  pad_S0_T9_out,  pad_S0_T10_out, pad_S0_T11_out,
               pad_S0_T12_out, pad_S0_T13_out, pad_S0_T14_out, pad_S0_T15_out,
  input  logic tdi,
  input  logic tms,
  input  logic tck,
  input  logic trst_n,
  output logic tdo
);

  logic [15:0]        w_addr;
  logic               w_op_wr;
  cfg_t               r_cfg;
  logic [3:0][W-1:0]  w_sides;
  logic [W-1:0]       w_out;
  logic               w_unused;

  // Pad T0 is the MSB of each side word.
  assign w_sides[0] = {pad_S0_T0_in,  pad_S0_T1_in,  pad_S0_T2_in,  pad_S0_T3_in,
                       pad_S0_T4_in,  pad_S0_T5_in,  pad_S0_T6_in,  pad_S0_T7_in,
                       pad_S0_T8_in,  pad_S0_T9_in,  pad_S0_T10_in, pad_S0_T11_in,
                       pad_S0_T12_in, pad_S0_T13_in, pad_S0_T14_in, pad_S0_T15_in};
  assign w_sides[1] = {pad_S1_T0_in,  pad_S1_T1_in,  pad_S1_T2_in,  pad_S1_T3_in,
                       pad_S1_T4_in,  pad_S1_T5_in,  pad_S1_T6_in,  pad_S1_T7_in,
                       pad_S1_T8_in,  pad_S1_T9_in,  pad_S1_T10_in, pad_S1_T11_in,
                       pad_S1_T12_in, pad_S1_T13_in, pad_S1_T14_in, pad_S1_T15_in};
  assign w_sides[2] = {pad_S2_T0_in,  pad_S2_T1_in,  pad_S2_T2_in,  pad_S2_T3_in,
                       pad_S2_T4_in,  pad_S2_T5_in,  pad_S2_T6_in,  pad_S2_T7_in,
                       pad_S2_T8_in,  pad_S2_T9_in,  pad_S2_T10_in, pad_S2_T11_in,
                       pad_S2_T12_in, pad_S2_T13_in, pad_S2_T14_in, pad_S2_T15_in};
  assign w_sides[3] = {pad_S3_T0_in,  pad_S3_T1_in,  pad_S3_T2_in,  pad_S3_T3_in,
                       pad_S3_T4_in,  pad_S3_T5_in,  pad_S3_T6_in,  pad_S3_T7_in,
                       pad_S3_T8_in,  pad_S3_T9_in,  pad_S3_T10_in, pad_S3_T11_in,
                       pad_S3_T12_in, pad_S3_T13_in, pad_S3_T14_in, pad_S3_T15_in};

  assign {pad_S0_T0_out,  pad_S0_T1_out,  pad_S0_T2_out,  pad_S0_T3_out,
          pad_S0_T4_out,  pad_S0_T5_out,  pad_S0_T6_out,  pad_S0_T7_out,
          pad_S0_T8_out,  pad_S0_T9_out,  pad_S0_T10_out, pad_S0_T11_out,
          pad_S0_T12_out, pad_S0_T13_out, pad_S0_T14_out, pad_S0_T15_out} = w_out;

  assign tdo = 1'b0;

  // JTAG and the undecoded upper address/data halves have no function.
  assign w_unused = ^{tdi, tms, tck, trst_n,
                      config_addr_in[CFG_AW-1:16], config_data_in[CFG_DW-1:16]};

  assign w_addr  = config_addr_in[15:0];
  assign w_op_wr = (w_addr == ADDR_OP);

  // Address 0 and unknown addresses fall through to the default arm.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_cfg <= '0;
    end else begin
      case (w_addr)
        ADDR_SRC_A:   r_cfg.src_a   <= config_data_in[2:0];
        ADDR_SRC_B:   r_cfg.src_b   <= config_data_in[2:0];
        ADDR_CONST:   r_cfg.cval    <= config_data_in[W-1:0];
        ADDR_OP:      r_cfg.op      <= config_data_in[3:0];
        ADDR_OUT_CFG: r_cfg.out_cfg <= config_data_in[1:0];
        default: ;
      endcase
    end
  end

  cgra_pe u_pe (
    .clk     (clk_in),
    .rst_n   (reset_in),
    .i_cfg   (r_cfg),
    .i_op_wr (w_op_wr),
    .i_sides (w_sides),
    .o_out   (w_out)
  );

endmodule

// File: tb/tb_cgra_top.sv
module tb_cgra_top;

  logic        clk;
  logic        rst_n;
  logic [31:0] cfg_addr;
  logic [31:0] cfg_data;
  logic [15:0] s0, s1, s2, s3;
  wire  [15:0] pad_out;
  logic        tdi, tms, tck, trst_n;
  wire         tdo;

  int n_checks;
  int n_errors;

  cgra_top dut (
    .clk_in(clk), .reset_in(rst_n),
    .config_addr_in(cfg_addr), .config_data_in(cfg_data),
    .pad_S0_T0_in(s0[15]),  .pad_S0_T1_in(s0[14]),  .pad_S0_T2_in(s0[13]),  .pad_S0_T3_in(s0[12]),
    .pad_S0_T4_in(s0[11]),  .pad_S0_T5_in(s0[10]),  .pad_S0_T6_in(s0[9]),   .pad_S0_T7_in(s0[8]),
    .pad_S0_T8_in(s0[7]),   .pad_S0_T9_in(s0[6]),   .pad_S0_T10_in(s0[5]),  .pad_S0_T11_in(s0[4]),
    .pad_S0_T12_in(s0[3]),  .pad_S0_T13_in(s0[2]),  .pad_S0_T14_in(s0[1]),  .pad_S0_T15_in(s0[0]),
    .pad_S1_T0_in(s1[15]),  .pad_S1_T1_in(s1[14]),  .pad_S1_T2_in(s1[13]),  .pad_S1_T3_in(s1[12]),
    .pad_S1_T4_in(s1[11]),  .pad_S1_T5_in(s1[10]),  .pad_S1_T6_in(s1[9]),   .pad_S1_T7_in(s1[8]),
    .pad_S1_T8_in(s1[7]),   .pad_S1_T9_in(s1[6]),   .pad_S1_T10_in(s1[5]),  .pad_S1_T11_in(s1[4]),
    .pad_S1_T12_in(s1[3]),  .pad_S1_T13_in(s1[2]),  .pad_S1_T14_in(s1[1]),  .pad_S1_T15_in(s1[0]),
    .pad_S2_T0_in(s2[15]),  .pad_S2_T1_in(s2[14]),  .pad_S2_T2_in(s2[13]),  .pad_S2_T3_in(s2[12]),
    .pad_S2_T4_in(s2[11]),  .pad_S2_T5_in(s2[10]),  .pad_S2_T6_in(s2[9]),   .pad_S2_T7_in(s2[8]),
    .pad_S2_T8_in(s2[7]),   .pad_S2_T9_in(s2[6]),   .pad_S2_T10_in(s2[5]),  .pad_S2_T11_in(s2[4]),
    .pad_S2_T12_in(s2[3]),  .pad_S2_T13_in(s2[2]),  .pad_S2_T14_in(s2[1]),  .pad_S2_T15_in(s2[0]),
    .pad_S3_T0_in(s3[15]),  .pad_S3_T1_in(s3[14]),  .pad_S3_T2_in(s3[13]),  .pad_S3_T3_in(s3[12]),
    .pad_S3_T4_in(s3[11]),  .pad_S3_T5_in(s3[10]),  .pad_S3_T6_in(s3[9]),   .pad_S3_T7_in(s3[8]),
    .pad_S3_T8_in(s3[7]),   .pad_S3_T9_in(s3[6]),   .pad_S3_T10_in(s3[5]),  .pad_S3_T11_in(s3[4]),
    .pad_S3_T12_in(s3[3]),  .pad_S3_T13_in(s3[2]),  .pad_S3_T14_in(s3[1]),  .pad_S3_T15_in(s3[0]),
    .pad_S0_T0_out(pad_out[15]),  .pad_S0_T1_out(pad_out[14]),  .pad_S0_T2_out(pad_out[13]),
    .pad_S0_T3_out(pad_out[12]),  .pad_S0_T4_out(pad_out[11]),  .pad_S0_T5_out(pad_out[10]),
    .pad_S0_T6_out(pad_out[9]),   .pad_S0_T7_out(pad_out[8]),   .pad_S0_T8_out(pad_out[7]),
    .pad_S0_T9_out(pad_out[6]),   .pad_S0_T10_out(pad_out[5]),  .pad_S0_T11_out(pad_out[4]),
    .pad_S0_T12_out(pad_out[3]),  .pad_S0_T13_out(pad_out[2]),  .pad_S0_T14_out(pad_out[1]),
    .pad_S0_T15_out(pad_out[0]),
    .tdi(tdi), .tms(tms), .tck(tck), .trst_n(trst_n), .tdo(tdo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One config word per call; the value is live from the next cycle on.
  task automatic cfg_wr(input logic [31:0] a, input logic [31:0] d);
    cfg_addr = a;
    cfg_data = d;
    @(posedge clk);
    #1;
    cfg_addr = '0;
    cfg_data = '0;
    $display("cfg write addr=0x%08h data=0x%08h", a, d);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] k;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[12];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    s0 = 16'hAAAA; s1 = 16'h5555; s2 = 16'h0000; s3 = 16'h1234;
    tdi = 1'b1; tms = 1'b1; tck = 1'b0; trst_n = 1'b1;

    // Reset, then 100 idle cycles with no configuration.
    tick(); tick();
    check("reset_out", pad_out, 16'h0000);
    check("reset_tdo", {15'd0, tdo}, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      tck = ~tck;
      check("idle_out", pad_out, 16'h0000);
      check("idle_tdo", {15'd0, tdo}, 16'h0000);
    end
    $display("idle phase done");

    // Pass-through of S2, combinational.
    cfg_wr(32'h0000_0001, 32'h2);
    cfg_wr(32'h0000_0004, 32'h0);
    cfg_wr(32'h0000_0005, 32'h1);
    for (int i = 0; i < 8; i++) begin
      s2 = 16'(3 + i);
      #1;
      check("pass_s2", pad_out, 16'(3 + i));
      $display("pass-through s2=0x%04h out=0x%04h", s2, pad_out);
      tick();
    end

    // Add with constant through the output register; upper addr bits ignored.
    cfg_wr(32'h0000_0002, 32'h4);
    cfg_wr(32'hABCD_0003, 32'hFFFF_0010);
    cfg_wr(32'h0000_0004, 32'h1);
    cfg_wr(32'h0000_0005, 32'h3);
    s2 = 16'hFFF5;
    tick();
    check("add_wrap_reg", pad_out, 16'h0005);
    s2 = 16'h0001;
    #1;
    check("add_reg_hold", pad_out, 16'h0005);
    tick();
    check("add_reg_next", pad_out, 16'h0011);
    $display("registered add done out=0x%04h", pad_out);

    // ALU table, A = S2, B = CONST, combinational output.
    cfg_wr(32'h0000_0005, 32'h1);
    vecs[0]  = '{4'd2,  16'h0003, 16'h0010, 16'hFFF3, "sub_wrap"};
    vecs[1]  = '{4'd3,  16'h0101, 16'h0100, 16'h0100, "mul_lo"};
    vecs[2]  = '{4'd4,  16'hF0F0, 16'h0FF0, 16'h00F0, "and"};
    vecs[3]  = '{4'd5,  16'hF000, 16'h000F, 16'hF00F, "or"};
    vecs[4]  = '{4'd6,  16'hFFFF, 16'h00FF, 16'hFF00, "xor"};
    vecs[5]  = '{4'd8,  16'h8000, 16'h0013, 16'h1000, "shr_b3_0"};
    vecs[6]  = '{4'd9,  16'h8000, 16'h0001, 16'h0001, "min_unsigned"};
    vecs[7]  = '{4'd10, 16'h8000, 16'h0001, 16'h8000, "max_unsigned"};
    vecs[8]  = '{4'd11, 16'h0007, 16'h0007, 16'h0001, "eq_true"};
    vecs[9]  = '{4'd11, 16'h0007, 16'h0008, 16'h0000, "eq_false"};
    vecs[10] = '{4'd13, 16'h1234, 16'h0001, 16'h0000, "op13_zero"};
    vecs[11] = '{4'd1,  16'hFFFF, 16'h0002, 16'h0001, "add_wrap"};
    for (int i = 0; i < 12; i++) begin
      cfg_wr(32'h0000_0003, {16'h0, vecs[i].k});
      cfg_wr(32'h0000_0004, {28'h0, vecs[i].op});
      s2 = vecs[i].a;
      #1;
      check(vecs[i].name, pad_out, vecs[i].exp);
      $display("alu op=%0d a=0x%04h k=0x%04h out=0x%04h", vecs[i].op, vecs[i].a, vecs[i].k, pad_out);
      tick();
    end

    // Accumulate S2=3; out shows the pre-update ACC.
    s2 = 16'h0003;
    cfg_wr(32'h0000_0001, 32'h2);
    cfg_wr(32'h0000_0004, 32'hC);
    for (int i = 0; i < 5; i++) begin
      check("acc_seq", pad_out, 16'(3 * i));
      $display("acc step %0d out=0x%04h", i, pad_out);
      tick();
    end
    check("acc_seq5", pad_out, 16'd15);
    cfg_wr(32'h0000_0004, 32'hC);
    check("acc_restart", pad_out, 16'h0000);
    tick();
    check("acc_after_restart", pad_out, 16'h0003);

    // Shift / compare with A from CONST, B from S2.
    cfg_wr(32'h0000_0001, 32'h4);
    cfg_wr(32'h0000_0003, 32'h1);
    cfg_wr(32'h0000_0002, 32'h2);
    cfg_wr(32'h0000_0004, 32'h7);
    s2 = 16'h0004;
    #1;
    check("shl", pad_out, 16'h0010);
    cfg_wr(32'h0000_0006, 32'hFFFF_FFFF);
    check("unknown_addr", pad_out, 16'h0010);
    cfg_wr(32'h0000_0004, 32'hB);
    s2 = 16'h0001;
    #1;
    check("eq_const", pad_out, 16'h0001);
    s2 = 16'h0002;
    #1;
    check("neq_const", pad_out, 16'h0000);

    // Reset in the middle of registered operation: A=1, B=S2=4, ADD.
    cfg_wr(32'h0000_0004, 32'h1);
    cfg_wr(32'h0000_0005, 32'h3);
    s2 = 16'h0004;
    tick();
    check("pre_reset", pad_out, 16'h0005);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", pad_out, 16'h0000);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_reset", pad_out, 16'h0000);
    end
    // Only OUT_CFG replayed: SRC_A=S0 and OP=pass prove the rest was cleared.
    s0 = 16'hBEEF;
    cfg_wr(32'h0000_0005, 32'h1);
    #1;
    check("reconfig_s0", pad_out, 16'hBEEF);
    $display("reset mid-operation done out=0x%04h", pad_out);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
